// File: rtl/seg_pkg.sv
// Shared constants for the segment-word capture block: hex glyphs, FSM states, default width.
package seg_pkg;

    localparam int NDIG_DEFAULT = 4;

    // Active-low glyphs, bit0 = segment A ... bit6 = segment G.
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational 7-segment glyph to hex nibble decoder with a legal-pattern flag.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        case (seg)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_word_capture.sv
// Assembles a multi-digit hex word from strobed 7-segment digit patterns.
// Optional macro SEG_STABLE_CHECK_EN: a digit is taken only after two matching consecutive strobes.
module seg_word_capture
    import seg_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [6:0]        seg_in,
    input  logic [2:0]        dig_sel,
    input  logic              seg_valid,
    output logic [4*NDIG-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              err_pat,
    output logic              err_seq
);

    localparam logic [2:0] LAST_IDX = 3'(NDIG - 1);

    cap_state_t        state;
    logic [2:0]        exp_idx;
    logic [4*NDIG-1:0] acc;
    logic [4*NDIG-1:0] acc_nx;
    logic [3:0]        nib;
    logic              legal;
    logic              stb;
    logic              take;

    seg_glyph_decode u_decode (
        .seg    (seg_in),
        .nibble (nib),
        .legal  (legal)
    );

`ifdef SEG_STABLE_CHECK_EN
    logic       prev_vld;
    logic [2:0] prev_sel;
    logic [6:0] prev_seg;

    assign stb = seg_valid && prev_vld && (prev_sel == dig_sel) && (prev_seg == seg_in);

    // A matched pair is consumed; an unmatched strobe becomes the new candidate.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_vld <= 1'b0;
        end else if (state == ST_HOLD) begin
            prev_vld <= 1'b0;
        end else if (seg_valid) begin
            if (stb) begin
                prev_vld <= 1'b0;
            end else begin
                prev_vld <= 1'b1;
                prev_sel <= dig_sel;
                prev_seg <= seg_in;
            end
        end
    end
`else
    assign stb = seg_valid;
`endif

    always_comb begin
        acc_nx = acc;
        for (int k = 0; k < NDIG; k++) begin
            if (int'(dig_sel) == k) acc_nx[4*k +: 4] = nib;
        end
    end

    assign take = stb && legal &&
                  ((state == ST_IDLE && dig_sel == 3'd0) ||
                   (state == ST_COLLECT && (dig_sel == exp_idx || dig_sel == 3'd0)));

    always_ff @(posedge clk) begin
        if (take) acc <= acc_nx;
    end

    assign word_valid = (state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            exp_idx  <= 3'd0;
            word_out <= '0;
            err_pat  <= 1'b0;
            err_seq  <= 1'b0;
        end else begin
            err_pat <= 1'b0;
            err_seq <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (stb && !legal) begin
                        err_pat <= 1'b1;
                    end else if (take) begin
                        exp_idx <= 3'd1;
                        if (NDIG == 1) begin
                            word_out <= acc_nx;
                            exp_idx  <= 3'd0;
                            state    <= ST_HOLD;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (stb) begin
                        if (!legal) begin
                            err_pat <= 1'b1;
                            exp_idx <= 3'd0;
                            state   <= ST_IDLE;
                        end else if (dig_sel == exp_idx) begin
                            if (exp_idx == LAST_IDX) begin
                                word_out <= acc_nx;
                                exp_idx  <= 3'd0;
                                state    <= ST_HOLD;
                            end else begin
                                exp_idx <= exp_idx + 3'd1;
                            end
                        end else if (dig_sel == 3'd0) begin
                            exp_idx <= 3'd1;
                        end else begin
                            err_seq <= 1'b1;
                            exp_idx <= 3'd0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (seg_valid)  err_seq <= 1'b1;
                    if (word_ready) state   <= ST_IDLE;
                end
                default: begin
                    exp_idx <= 3'd0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_word_capture.sv
// Bench for seg_word_capture: directed vector table, hand sequences, and random traffic vs. a digit-list model.
module tb_seg_word_capture;

    localparam int NDIG = 4;
`ifdef SEG_STABLE_CHECK_EN
    localparam bit STABLE = 1'b1;
`else
    localparam bit STABLE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  seg_in;
    logic [2:0]  dig_sel;
    logic        seg_valid;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        err_pat;
    logic        err_seq;

    int passed = 0;
    int total  = 0;

    seg_word_capture #(.NDIG(NDIG)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seg_in     (seg_in),
        .dig_sel    (dig_sel),
        .seg_valid  (seg_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .err_pat    (err_pat),
        .err_seq    (err_seq)
    );

    always #5 clk = ~clk;

    logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: list of digits collected so far plus a holding flag.
    int          m_digits [$];
    bit          m_hold;
    logic [15:0] m_word;
    bit          m_pat, m_seq;
    bit          p_have;
    logic [2:0]  p_sel;
    logic [6:0]  p_seg;

    function automatic int glyph_value(input logic [6:0] g);
        for (int i = 0; i < 16; i++) if (glyphs[i] == g) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_digits.delete();
        m_hold = 0; m_word = '0; m_pat = 0; m_seq = 0; p_have = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [2:0] s, input logic [6:0] g, input bit r);
        bit q;
        int val;
        m_pat = 0; m_seq = 0;
        if (m_hold) begin
            if (v) m_seq = 1;
            if (r) m_hold = 0;
            p_have = 0;
            return;
        end
        q = v;
        if (STABLE && v) begin
            q = p_have && p_sel == s && p_seg == g;
            p_have = !q;
            p_sel = s; p_seg = g;
        end
        if (!q) return;
        val = glyph_value(g);
        if (val < 0) begin
            m_pat = 1; m_digits.delete(); return;
        end
        if (s == 0) begin
            m_digits.delete(); m_digits.push_back(val);
        end else if (m_digits.size() > 0 && int'(s) == m_digits.size()) begin
            m_digits.push_back(val);
        end else if (m_digits.size() > 0) begin
            m_seq = 1; m_digits.delete();
        end
        if (m_digits.size() == NDIG) begin
            m_word = '0;
            for (int k = 0; k < NDIG; k++) m_word = m_word + 16'(m_digits[k] * (1 << (4 * k)));
            m_hold = 1;
            m_digits.delete();
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] outs();
        return {13'd0, word_out, word_valid, err_pat, err_seq};
    endfunction

    task automatic cycle(input bit v, input logic [2:0] s, input logic [6:0] g, input bit r);
        seg_valid = v; dig_sel = s; seg_in = g; word_ready = r;
        @(posedge clk);
        #1;
    endtask

    // A digit strobe; the stable-check build needs the pattern presented twice.
    task automatic strobe(input logic [2:0] s, input logic [6:0] g);
        if (STABLE) cycle(1, s, g, 0);
        cycle(1, s, g, 0);
    endtask

    task automatic do_reset();
        reset_n = 0; seg_valid = 0; word_ready = 0; dig_sel = 0; seg_in = 7'h7F;
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    typedef struct {
        bit         v;
        logic [2:0] s;
        logic [6:0] g;
        bit         r;
        logic [15:0] e_word;
        bit         e_wv, e_pat, e_seq;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input bit v, input logic [2:0] s, input logic [6:0] g, input bit r,
                                input logic [15:0] w, input bit wv, input bit ep, input bit es);
        vec_t x;
        x.v = v; x.s = s; x.g = g; x.r = r; x.e_word = w; x.e_wv = wv; x.e_pat = ep; x.e_seq = es;
        tbl.push_back(x);
    endfunction

    initial begin
        do_reset();
        check("reset_state", outs(), 32'd0);

`ifndef SEG_STABLE_CHECK_EN
        add(1, 0, 7'h79, 0, 16'h0000, 0, 0, 0);
        add(1, 1, 7'h24, 0, 16'h0000, 0, 0, 0);
        add(1, 2, 7'h30, 0, 16'h0000, 0, 0, 0);
        add(1, 3, 7'h12, 0, 16'h5321, 1, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 7'h7F, 0, 16'h5321, 1, 0, 0);
        add(0, 0, 7'h7F, 1, 16'h5321, 0, 0, 0);
        add(0, 0, 7'h7F, 0, 16'h5321, 0, 0, 0);
        add(1, 0, 7'h40, 0, 16'h5321, 0, 0, 0);
        add(1, 2, 7'h00, 0, 16'h5321, 0, 0, 1);
        add(0, 0, 7'h7F, 0, 16'h5321, 0, 0, 0);
        add(1, 0, 7'h40, 0, 16'h5321, 0, 0, 0);
        add(1, 1, 7'h7F, 0, 16'h5321, 0, 1, 0);
        add(1, 2, 7'h24, 0, 16'h5321, 0, 0, 0);
        add(1, 3, 7'h12, 0, 16'h5321, 0, 0, 0);
        add(1, 0, 7'h06, 0, 16'h5321, 0, 0, 0);
        add(1, 1, 7'h02, 0, 16'h5321, 0, 0, 0);
        add(1, 2, 7'h40, 0, 16'h5321, 0, 0, 0);
        add(1, 3, 7'h19, 0, 16'h406E, 1, 0, 0);
        add(1, 0, 7'h79, 0, 16'h406E, 1, 0, 1);
        add(1, 0, 7'h79, 1, 16'h406E, 0, 0, 1);
        add(0, 0, 7'h7F, 0, 16'h406E, 0, 0, 0);
        add(1, 0, 7'h79, 0, 16'h406E, 0, 0, 0);
        add(1, 1, 7'h24, 0, 16'h406E, 0, 0, 0);
        add(1, 0, 7'h30, 0, 16'h406E, 0, 0, 0);
        add(1, 1, 7'h00, 0, 16'h406E, 0, 0, 0);
        add(1, 2, 7'h08, 0, 16'h406E, 0, 0, 0);
        add(1, 3, 7'h03, 0, 16'hBA83, 1, 0, 0);
        add(0, 0, 7'h7F, 1, 16'hBA83, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, tbl[i].s, tbl[i].g, tbl[i].r);
            check($sformatf("vec%0d", i), outs(),
                  {13'd0, tbl[i].e_word, tbl[i].e_wv, tbl[i].e_pat, tbl[i].e_seq});
        end
`else
        strobe(0, 7'h79);
        cycle(1, 0, 7'h24, 0);
        check("stable_mismatch_nothing", outs(), 32'd0);
        cycle(1, 0, 7'h24, 0);
        strobe(1, 7'h79);
        strobe(2, 7'h79);
        cycle(1, 3, 7'h79, 0);
        check("stable_first_only", outs(), 32'd0);
        cycle(1, 3, 7'h79, 0);
        check("stable_word", outs(), {13'd0, 16'h1112, 3'b100});
        cycle(0, 0, 7'h7F, 1);
`endif

        // Reset in the middle of a word, then a fresh word.
        strobe(0, 7'h79);
        strobe(1, 7'h24);
        do_reset();
        check("reset_mid_collect", outs(), 32'd0);
        strobe(0, 7'h0E);
        strobe(1, 7'h08);
        strobe(2, 7'h00);
        strobe(3, 7'h40);
        check("word_08AF", outs(), {13'd0, 16'h08AF, 3'b100});
        cycle(0, 0, 7'h7F, 0);
        check("hold_stable", outs(), {13'd0, 16'h08AF, 3'b100});
        do_reset();
        check("reset_in_hold", outs(), 32'd0);
        cycle(0, 0, 7'h7F, 0);
        check("reset_no_err", outs(), 32'd0);

        // Random traffic against the model.
        model_reset();
        begin
            bit v, r, lastv;
            logic [2:0] s, lasts;
            logic [6:0] g, lastg;
            lastv = 0; lasts = 0; lastg = 7'h40;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 299) == 0) begin
                    do_reset();
                    model_reset();
                    check("rnd_reset", outs(), 32'd0);
                    continue;
                end
                if (lastv && $urandom_range(0, 1) == 1) begin
                    v = 1; s = lasts; g = lastg;
                end else begin
                    v = ($urandom_range(0, 99) < 60);
                    if ($urandom_range(0, 99) < 75) s = 3'(m_digits.size());
                    else s = 3'($urandom_range(0, 7));
                    if ($urandom_range(0, 99) < 92) g = glyphs[$urandom_range(0, 15)];
                    else g = 7'($urandom_range(0, 127));
                end
                r = ($urandom_range(0, 99) < 30);
                lastv = v; lasts = s; lastg = g;
                seg_valid = v; dig_sel = s; seg_in = g; word_ready = r;
                @(posedge clk);
                model_step(v, s, g, r);
                #1;
                check($sformatf("rnd%0d", i), outs(), {13'd0, m_word, m_hold, m_pat, m_seq});
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
